// File: rtl/j1b_memsys.sv
// ---------------------------------------------------------------------------
// j1b_memsys
//
// Unified code/data memory for the J1B core with a built-in streaming loader.
// One 32-bit-wide RAM serves the 16-bit instruction fetch port and the 32-bit
// data port. A valid/ready loader fills the RAM from word 0 upward while the
// core is held. The fill happens after reset (LOAD_ON_RESET) or when ld_start
// is pulsed in RUN.
//
// Parameters
//   ADDR_BITS      RAM word-address width, DEPTH = 2**ADDR_BITS words
//   LOAD_ON_RESET  1: enter LOAD after reset, 0: go straight to RUN
//
// Ports
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   code_addr      halfword fetch address, bit 0 picks upper/lower half
//   insn           registered instruction, forced to zero outside RUN
//   mem_addr       data byte address, word index = mem_addr[ADDR_BITS+1:2]
//   mem_wr         data write strobe, honoured in RUN only
//   mem_wdata      data write value
//   mem_rdata      registered data read value
//   ld_start       reload request, honoured in RUN only
//   ld_valid       loader beat valid
//   ld_ready       loader beat accepted when ld_valid && ld_ready
//   ld_data        loader word
//   ld_last        final beat of the image
//   cpu_hold       core must be held while this is high
//   ld_count       words written by the current or last load
//   ld_sum         sum of loaded words, mod 2^32
//   ld_trunc       sticky: load stopped at RAM full without ld_last
// ---------------------------------------------------------------------------
module j1b_memsys #(
    parameter int ADDR_BITS     = 13,
    parameter bit LOAD_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS:0]   code_addr,
    output logic [15:0]          insn,
    input  logic [15:0]          mem_addr,
    input  logic                 mem_wr,
    input  logic [31:0]          mem_wdata,
    output logic [31:0]          mem_rdata,
    input  logic                 ld_start,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [31:0]          ld_data,
    input  logic                 ld_last,
    output logic                 cpu_hold,
    output logic [ADDR_BITS:0]   ld_count,
    output logic [31:0]          ld_sum,
    output logic                 ld_trunc
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        ST_START,
        ST_LOAD,
        ST_DRAIN,
        ST_RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]          ram [DEPTH];
    logic [ADDR_BITS-1:0] ptr;
    logic [ADDR_BITS-1:0] data_word;
    logic [ADDR_BITS-1:0] code_word;
    logic [31:0]          fetch_word;
    logic                 beat;
    logic                 at_full;
    logic                 load_enter;
    logic                 data_write;
    logic                 unused_addr_bits;

    // The fill pointer always equals the low bits of ld_count: both are
    // cleared together on entry to LOAD and advance together on each beat.
    // The load stops at the top word, so the pointer never has to wrap.
    assign ptr        = ld_count[ADDR_BITS-1:0];
    assign data_word  = mem_addr[ADDR_BITS+1:2];
    assign code_word  = code_addr[ADDR_BITS:1];
    assign fetch_word = ram[code_word];

    // Byte-offset bits and address bits above the RAM are deliberately
    // ignored, so data addresses alias.
    assign unused_addr_bits = ^{mem_addr[15:ADDR_BITS+2], mem_addr[1:0]};

    assign ld_ready   = (state == ST_LOAD);
    assign cpu_hold   = (state != ST_RUN);
    assign beat       = ld_ready && ld_valid;
    assign at_full    = (ptr == {ADDR_BITS{1'b1}});
    assign data_write = (state == ST_RUN) && mem_wr;

    // Counters restart on entry to LOAD from either START or RUN.
    assign load_enter = (state_next == ST_LOAD) && (state != ST_LOAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_START;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN gives the last loaded word one cycle to land before the core
    // is released and makes its first fetch.
    always_comb begin
        state_next = state;
        case (state)
            ST_START: state_next = LOAD_ON_RESET ? ST_LOAD : ST_RUN;
            ST_LOAD: begin
                if (beat && (ld_last || at_full)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: state_next = ST_RUN;
            ST_RUN: begin
                if (ld_start) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_START;
        endcase
    end

    // A beat accepted at the top word without ld_last still ends the load.
    // ld_trunc records that the image did not fit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_count <= '0;
            ld_sum   <= '0;
            ld_trunc <= 1'b0;
        end else if (load_enter) begin
            ld_count <= '0;
            ld_sum   <= '0;
            ld_trunc <= 1'b0;
        end else if (beat) begin
            ld_count <= ld_count + (ADDR_BITS + 1)'(1);
            ld_sum   <= ld_sum + ld_data;
            if (at_full && !ld_last) begin
                ld_trunc <= 1'b1;
            end
        end
    end

    // The loader writes only in LOAD and the data port only in RUN, so the
    // two writers never collide. Reset does not clear the array.
    always_ff @(posedge clk) begin
        if (beat) begin
            ram[ptr] <= ld_data;
        end else if (data_write) begin
            ram[data_word] <= mem_wdata;
        end
    end

    // Both read ports sample the array before this edge's write lands, so a
    // same-word read during a write returns the old contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            insn      <= 16'h0000;
            mem_rdata <= 32'h0000_0000;
        end else begin
            mem_rdata <= ram[data_word];
            if (state == ST_RUN) begin
                insn <= code_addr[0] ? fetch_word[31:16] : fetch_word[15:0];
            end else begin
                insn <= 16'h0000;
            end
        end
    end

endmodule
